// File: rtl/m_ifetch_pkg.sv
// rtl/m_ifetch_pkg.sv - shared constants for the instruction-fetch stage
package m_ifetch_pkg;

   localparam logic [31:0] NOP          = {21'h0, 11'h20};
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [5:0] {
      OP_ADD  = 6'h00,
      OP_BEQ  = 6'h04,
      OP_BNE  = 6'h05,
      OP_ADDI = 6'h08,
      OP_LW   = 6'h23,
      OP_SW   = 6'h2B,
      OP_HALT = 6'h3F
   } opcode_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } fetch_entry_t;

endpackage

// File: rtl/m_ifq.sv
// rtl/m_ifq.sv - DEPTH-entry FIFO of {pc, ir} with push, pop, flush and count
module m_ifq
   import m_ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        w_push,
   input  logic [31:0] w_push_pc,
   input  logic [31:0] w_push_ir,
   input  logic        w_pop,
   input  logic        w_flush,
   output logic [31:0] r_head_pc,
   output logic [31:0] r_head_ir,
   output logic [2:0]  r_count
);

   localparam int AW = (DEPTH > 2) ? 2 : 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = w_pop && !w_flush && (cnt_q != 3'd0);
   assign do_push = w_push && !w_flush && ((cnt_q != 3'(DEPTH)) || do_pop);

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (w_flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = 3'd0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + {2'b00, do_push} - {2'b00, do_pop};
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= 3'd0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge w_clk) begin
      if (do_push) begin
         mem_q[wr_q] <= '{pc: w_push_pc, ir: w_push_ir};
      end
   end

   assign r_head_pc = mem_q[rd_q].pc;
   assign r_head_ir = mem_q[rd_q].ir;
   assign r_count   = cnt_q;

endmodule

// File: rtl/m_ifetch.sv
// rtl/m_ifetch.sv - fetch stage: PC, credit-based issue, squash on redirect/halt.
// IFETCH_PERF_EN adds r_nfetch/r_nstall performance counters.
module m_ifetch
   import m_ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        w_stall,
   input  logic        w_taken,
   input  logic [31:0] w_tpc,
   input  logic        w_halt,
   output logic [11:0] r_imem_addr,
   input  logic [31:0] w_imem_data,
   output logic [31:0] r_ir,
   output logic [31:0] r_pc,
   output logic [31:0] r_pc4,
   output logic        r_valid
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] r_nfetch,
   output logic [31:0] r_nstall
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ipc_q, ipc_d;
   logic        inflight_q, inflight_d;
   logic        halt_q, halt_d;

   logic        flush;
   logic        pop;
   logic        issue;
   logic        rsp_push;
   logic [3:0]  occ;
   logic [2:0]  q_count;
   logic [31:0] q_pc;
   logic [31:0] q_ir;
   logic        q_valid;

   assign q_valid  = (q_count != 3'd0);
   assign pop      = q_valid && !w_stall;
   assign flush    = w_halt || w_taken;
   // A response returning in a redirect/halt cycle is squashed by not pushing it.
   assign rsp_push = inflight_q && !flush;
   assign occ      = {1'b0, q_count} + {3'b000, inflight_q} - {3'b000, pop};
   assign issue    = !halt_q && !flush && (occ < 4'(DEPTH));

   always_comb begin
      pc_d       = pc_q;
      ipc_d      = ipc_q;
      inflight_d = issue;
      halt_d     = halt_q || w_halt;
      if (w_halt || halt_q) begin
         pc_d = RESET_PC;
      end else if (w_taken) begin
         pc_d = w_tpc;
      end else if (issue) begin
         pc_d  = pc_q + 32'd4;
         ipc_d = pc_q;
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         pc_q       <= RESET_PC;
         ipc_q      <= RESET_PC;
         inflight_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ipc_q      <= ipc_d;
         inflight_q <= inflight_d;
         halt_q     <= halt_d;
      end
   end

   m_ifq #(
      .DEPTH(DEPTH)
   ) u_ifq (
      .w_clk     (w_clk),
      .w_rst     (w_rst),
      .w_push    (rsp_push),
      .w_push_pc (ipc_q),
      .w_push_ir (w_imem_data),
      .w_pop     (pop),
      .w_flush   (flush),
      .r_head_pc (q_pc),
      .r_head_ir (q_ir),
      .r_count   (q_count)
   );

   assign r_imem_addr = pc_q[13:2];
   assign r_valid     = q_valid;
   assign r_ir        = q_valid ? q_ir : NOP;
   assign r_pc        = q_valid ? q_pc : 32'd0;
   assign r_pc4       = q_valid ? (q_pc + 32'd4) : 32'd0;

   // The issue credit guarantees a free slot for every returning word.
   always_ff @(posedge w_clk) begin
      if (!w_rst) begin
         assert (!(rsp_push && (q_count == 3'(DEPTH))));
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] nfetch_q;
   logic [31:0] nstall_q;

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         nfetch_q <= 32'd0;
         nstall_q <= 32'd0;
      end else begin
         if (pop)                nfetch_q <= nfetch_q + 32'd1;
         if (q_valid && w_stall) nstall_q <= nstall_q + 32'd1;
      end
   end

   assign r_nfetch = nfetch_q;
   assign r_nstall = nstall_q;
`endif

endmodule

// File: tb/tb_m_ifetch.sv
// tb/tb_m_ifetch.sv - directed self-checking bench for m_ifetch
module tb_m_ifetch;

   logic        w_clk = 1'b0;
   logic        w_rst;
   logic        w_stall;
   logic        w_taken;
   logic [31:0] w_tpc;
   logic        w_halt;
   logic [11:0] r_imem_addr;
   logic [31:0] w_imem_data;
   logic [31:0] r_ir;
   logic [31:0] r_pc;
   logic [31:0] r_pc4;
   logic        r_valid;
`ifdef IFETCH_PERF_EN
   logic [31:0] r_nfetch;
   logic [31:0] r_nstall;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] imem [4096];

   always #5 w_clk = ~w_clk;

   always @(posedge w_clk) w_imem_data <= imem[r_imem_addr];

   m_ifetch dut (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .w_stall     (w_stall),
      .w_taken     (w_taken),
      .w_tpc       (w_tpc),
      .w_halt      (w_halt),
      .r_imem_addr (r_imem_addr),
      .w_imem_data (w_imem_data),
      .r_ir        (r_ir),
      .r_pc        (r_pc),
      .r_pc4       (r_pc4),
      .r_valid     (r_valid)
`ifdef IFETCH_PERF_EN
      ,
      .r_nfetch    (r_nfetch),
      .r_nstall    (r_nstall)
`endif
   );

   task automatic step(input int n);
      repeat (n) @(posedge w_clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: reset just released, state still at reset values.
   task automatic do_reset();
      w_rst = 1'b1; w_stall = 1'b0; w_taken = 1'b0; w_halt = 1'b0; w_tpc = 32'd0;
      step(2);
      w_rst = 1'b0;
   endtask

   task automatic test_reset();
      w_rst = 1'b1; w_stall = 1'b0; w_taken = 1'b0; w_halt = 1'b0; w_tpc = 32'd0;
      step(2);
      total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", r_valid); end
      total++; if (r_ir !== 32'h0000_0020) begin bad++; $display("FAIL reset_ir: got %h want 00000020", r_ir); end
      total++; if (r_pc !== 32'd0 || r_pc4 !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h/%h want 0/0", r_pc, r_pc4); end
      total++; if (r_imem_addr !== 12'd0) begin bad++; $display("FAIL reset_addr: got %h want 000", r_imem_addr); end
`ifdef IFETCH_PERF_EN
      total++; if (r_nfetch !== 32'd0 || r_nstall !== 32'd0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", r_nfetch, r_nstall); end
`endif
      w_rst = 1'b0;
   endtask

   task automatic test_freerun();
      logic [31:0] exp_pc;
      logic [31:0] exp_ir;
      do_reset();
      step(1);
      total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL fr_cycle1_valid: got %b want 0", r_valid); end
      step(1);
      for (int k = 0; k < 6; k++) begin
         exp_pc = 32'(4 * k);
         exp_ir = 32'hC0DE_0000 + 32'(k);
         total++;
         if (r_valid !== 1'b1 || r_pc !== exp_pc || r_ir !== exp_ir || r_pc4 !== exp_pc + 32'd4) begin
            bad++; $display("FAIL fr_seq%0d: got v=%b pc=%h ir=%h pc4=%h want v=1 pc=%h ir=%h pc4=%h",
                            k, r_valid, r_pc, r_ir, r_pc4, exp_pc, exp_ir, exp_pc + 32'd4);
         end
         step(1);
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      do_reset();
      step(3);
      w_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (r_valid !== 1'b1 || r_pc !== 32'd4 || r_ir !== 32'hC0DE_0001 || r_pc4 !== 32'd8) begin
            bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h ir=%h want v=1 pc=00000004 ir=c0de0001", k, r_valid, r_pc, r_ir);
         end
         step(1);
      end
      w_stall = 1'b0;
      total++; if (r_pc !== 32'd4 || r_ir !== 32'hC0DE_0001) begin bad++; $display("FAIL stall_release: got pc=%h ir=%h want 00000004 c0de0001", r_pc, r_ir); end
`ifdef IFETCH_PERF_EN
      total++; if (r_nstall !== 32'd3 || r_nfetch !== 32'd1) begin bad++; $display("FAIL stall_perf: got nstall=%0d nfetch=%0d want 3 1", r_nstall, r_nfetch); end
`endif
      step(1);
      for (int k = 2; k < 6; k++) begin
         exp_pc = 32'(4 * k);
         total++;
         if (r_valid !== 1'b1 || r_pc !== exp_pc || r_ir !== 32'hC0DE_0000 + 32'(k)) begin
            bad++; $display("FAIL stall_after%0d: got v=%b pc=%h ir=%h want v=1 pc=%h", k, r_valid, r_pc, r_ir, exp_pc);
         end
         step(1);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      step(4);
      total++; if (r_pc !== 32'd8) begin bad++; $display("FAIL redir_pre: got pc=%h want 00000008", r_pc); end
      w_taken = 1'b1; w_tpc = 32'h40;
      step(1);
      w_taken = 1'b0; w_tpc = 32'd0;
      total++; if (r_valid !== 1'b0 || r_imem_addr !== 12'd16) begin bad++; $display("FAIL redir_next: got v=%b addr=%h want v=0 addr=010", r_valid, r_imem_addr); end
      step(1);
      total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL redir_gap: got v=%b want 0", r_valid); end
      step(1);
      total++; if (r_valid !== 1'b1 || r_pc !== 32'h40 || r_ir !== 32'hC0DE_0010) begin bad++; $display("FAIL redir_first: got v=%b pc=%h ir=%h want v=1 pc=00000040 ir=c0de0010", r_valid, r_pc, r_ir); end
      step(1);
      total++; if (r_pc !== 32'h44 || r_ir !== 32'hC0DE_0011) begin bad++; $display("FAIL redir_second: got pc=%h ir=%h want 00000044 c0de0011", r_pc, r_ir); end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      step(3);
      w_taken = 1'b1; w_stall = 1'b1; w_tpc = 32'h100;
      step(1);
      w_taken = 1'b0; w_stall = 1'b0; w_tpc = 32'd0;
      total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rs_flush: got v=%b pc=%h want v=0", r_valid, r_pc); end
      step(2);
      total++; if (r_valid !== 1'b1 || r_pc !== 32'h100 || r_ir !== 32'hC0DE_0040) begin bad++; $display("FAIL rs_first: got v=%b pc=%h ir=%h want v=1 pc=00000100 ir=c0de0040", r_valid, r_pc, r_ir); end
      step(1);
      total++; if (r_pc !== 32'h104) begin bad++; $display("FAIL rs_second: got pc=%h want 00000104", r_pc); end
   endtask

   task automatic test_halt();
      do_reset();
      step(4);
      w_halt = 1'b1; w_taken = 1'b1; w_tpc = 32'h80;
      step(1);
      w_halt = 1'b0; w_taken = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) w_taken = 1'b1;
         total++;
         if (r_valid !== 1'b0 || r_imem_addr !== 12'd0) begin
            bad++; $display("FAIL halt_hold%0d: got v=%b addr=%h want v=0 addr=000", k, r_valid, r_imem_addr);
         end
         step(1);
         w_taken = 1'b0;
      end
      do_reset();
      step(2);
      total++; if (r_valid !== 1'b1 || r_pc !== 32'd0 || r_ir !== 32'hC0DE_0000) begin bad++; $display("FAIL halt_restart: got v=%b pc=%h ir=%h want v=1 pc=0 ir=c0de0000", r_valid, r_pc, r_ir); end
   endtask

   task automatic test_wrap();
      do_reset();
      step(3);
      w_taken = 1'b1; w_tpc = 32'h3FFC;
      step(1);
      w_taken = 1'b0; w_tpc = 32'd0;
      total++; if (r_imem_addr !== 12'd4095) begin bad++; $display("FAIL wrap_addr_hi: got %0d want 4095", r_imem_addr); end
      step(1);
      total++; if (r_imem_addr !== 12'd0) begin bad++; $display("FAIL wrap_addr_lo: got %0d want 0", r_imem_addr); end
      step(1);
      total++; if (r_pc !== 32'h3FFC || r_ir !== 32'hC0DE_0FFF) begin bad++; $display("FAIL wrap_pc_hi: got pc=%h ir=%h want 00003ffc c0de0fff", r_pc, r_ir); end
      step(1);
      total++; if (r_pc !== 32'h4000 || r_ir !== 32'hC0DE_0000 || r_pc4 !== 32'h4004) begin bad++; $display("FAIL wrap_pc_lo: got pc=%h ir=%h pc4=%h want 00004000 c0de0000 00004004", r_pc, r_ir, r_pc4); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(4);
      w_rst = 1'b1;
      step(1);
      total++; if (r_valid !== 1'b0 || r_ir !== 32'h0000_0020) begin bad++; $display("FAIL rmid_clear: got v=%b ir=%h want v=0 ir=00000020", r_valid, r_ir); end
      w_rst = 1'b0;
      step(1);
      total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rmid_c1: got v=%b want 0", r_valid); end
      step(1);
      total++; if (r_valid !== 1'b1 || r_pc !== 32'd0 || r_ir !== 32'hC0DE_0000) begin bad++; $display("FAIL rmid_c2: got v=%b pc=%h ir=%h want v=1 pc=0 ir=c0de0000", r_valid, r_pc, r_ir); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) imem[i] = 32'hC0DE_0000 + 32'(i);
      test_reset();
      test_freerun();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
